// File: rtl/rs_dec_word_packer.sv
// rs_dec_word_packer
// Repacks the decoded RS message byte stream (AXI-Stream, 8 bit) into 32-bit
// words, first byte in [31:24], on a valid/ready output. Packing is blind to
// packet boundaries; a separate framing counter checks tlast against the fixed
// packet length, pulses framing errors and counts packets.

module rs_dec_word_packer #(
    parameter int unsigned PKT_BYTES = 229
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    input  logic        data_rdy_i,
    output logic        err_tlast_missing,
    output logic        err_tlast_unexpected,
    output logic [15:0] pkt_count
);

    localparam logic [7:0] LAST_POS = 8'(PKT_BYTES);

    // Accumulator: three leading bytes of the word being built plus lane index.
    logic [23:0] r_acc_q, w_acc_d;
    logic [1:0]  r_lane_q, w_lane_d;

    // Output register.
    logic [31:0] r_data_q, w_data_d;
    logic        r_valid_q, w_valid_d;

    // Framing state: 1-based byte position within the current packet.
    logic [7:0]  r_pos_q, w_pos_d;
    logic [15:0] r_pkt_cnt_q, w_pkt_cnt_d;
    logic        r_err_miss_q, w_err_miss_d;
    logic        r_err_unexp_q, w_err_unexp_d;

    logic        w_acc;
    logic        w_xfer;
    logic        w_load;
    logic        w_pos_last;

    // Byte handshake: only the 4th byte needs a free (or freeing) output register.
    always_comb begin
        s_axis_tready = (r_lane_q != 2'd3) || !r_valid_q || data_rdy_i;
        w_acc         = s_axis_tvalid && s_axis_tready;
        w_xfer        = r_valid_q && data_rdy_i;
        w_load        = w_acc && (r_lane_q == 2'd3);
        w_pos_last    = (r_pos_q == LAST_POS);
    end

    // Next state of the packing datapath; a reload wins over a transfer clear.
    always_comb begin
        w_acc_d   = r_acc_q;
        w_lane_d  = r_lane_q;
        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;

        if (w_xfer) begin
            w_valid_d = 1'b0;
        end

        if (w_acc) begin
            if (w_load) begin
                w_data_d  = {r_acc_q, s_axis_tdata};
                w_valid_d = 1'b1;
                w_lane_d  = 2'd0;
            end else begin
                w_acc_d  = {r_acc_q[15:0], s_axis_tdata};
                w_lane_d = r_lane_q + 2'd1;
            end
        end
    end

    // Next state of the framing checker; any tlast resyncs the position.
    always_comb begin
        w_pos_d       = r_pos_q;
        w_pkt_cnt_d   = r_pkt_cnt_q;
        w_err_miss_d  = 1'b0;
        w_err_unexp_d = 1'b0;

        if (w_acc) begin
            if (w_pos_last) begin
                w_pos_d = 8'd1;
                if (s_axis_tlast) begin
                    w_pkt_cnt_d = r_pkt_cnt_q + 16'd1;
                end else begin
                    w_err_miss_d = 1'b1;
                end
            end else if (s_axis_tlast) begin
                w_pos_d       = 8'd1;
                w_pkt_cnt_d   = r_pkt_cnt_q + 16'd1;
                w_err_unexp_d = 1'b1;
            end else begin
                w_pos_d = r_pos_q + 8'd1;
            end
        end
    end

    // State registers; reset discards any partial word and restarts framing.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_q       <= 24'd0;
            r_lane_q      <= 2'd0;
            r_data_q      <= 32'd0;
            r_valid_q     <= 1'b0;
            r_pos_q       <= 8'd1;
            r_pkt_cnt_q   <= 16'd0;
            r_err_miss_q  <= 1'b0;
            r_err_unexp_q <= 1'b0;
        end else begin
            r_acc_q       <= w_acc_d;
            r_lane_q      <= w_lane_d;
            r_data_q      <= w_data_d;
            r_valid_q     <= w_valid_d;
            r_pos_q       <= w_pos_d;
            r_pkt_cnt_q   <= w_pkt_cnt_d;
            r_err_miss_q  <= w_err_miss_d;
            r_err_unexp_q <= w_err_unexp_d;
        end
    end

    // Output drive.
    always_comb begin
        data_o               = r_data_q;
        data_valid_o         = r_valid_q;
        err_tlast_missing    = r_err_miss_q;
        err_tlast_unexpected = r_err_unexp_q;
        pkt_count            = r_pkt_cnt_q;
    end

endmodule

// File: tb/tb_rs_dec_word_packer.sv
// Directed self-checking bench for rs_dec_word_packer (PKT_BYTES = 229).
// Inputs are driven on the falling edge; outputs are sampled between edges.

module tb_rs_dec_word_packer;

    logic        core_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic [7:0]  s_axis_tdata  = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast  = 1'b0;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic        data_rdy_i = 1'b1;
    logic        err_tlast_missing;
    logic        err_tlast_unexpected;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_miss   = 0;
    int n_unexp  = 0;

    logic [31:0] got[$];
    logic [7:0]  exp_bytes[$];

    rs_dec_word_packer #(
        .PKT_BYTES (229)
    ) u_dut (
        .core_clk             (core_clk),
        .rst_n                (rst_n),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .s_axis_tlast         (s_axis_tlast),
        .data_o               (data_o),
        .data_valid_o         (data_valid_o),
        .data_rdy_i           (data_rdy_i),
        .err_tlast_missing    (err_tlast_missing),
        .err_tlast_unexpected (err_tlast_unexpected),
        .pkt_count            (pkt_count)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Word and error-pulse monitor, sampled mid-cycle with inputs settled.
    always @(negedge core_clk) begin
        #2;
        if (rst_n) begin
            if (data_valid_o && data_rdy_i) got.push_back(data_o);
            if (err_tlast_missing) n_miss++;
            if (err_tlast_unexpected) n_unexp++;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard;
        guard = 0;
        s_axis_tdata  = b;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && guard < 200) begin
            @(negedge core_clk);
            #1;
            guard++;
        end
        if (guard >= 200) check("tready_timeout", {31'd0, s_axis_tready}, 32'd1);
        @(negedge core_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge core_clk);
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'd0;
        data_rdy_i    = 1'b1;
        repeat (2) @(negedge core_clk);
        rst_n = 1'b1;
        got.delete();
        exp_bytes.delete();
        n_miss  = 0;
        n_unexp = 0;
    endtask

    // Compare collected words against exp_bytes packed MSB-first.
    task automatic check_words(input string tag, input int n_words);
        logic [31:0] w;
        check({tag, "_nwords"}, got.size(), n_words);
        for (int i = 0; i < n_words && i < got.size(); i++) begin
            w = {exp_bytes[4*i], exp_bytes[4*i+1], exp_bytes[4*i+2], exp_bytes[4*i+3]};
            check($sformatf("%s_w%0d", tag, i), got[i], w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_stall;
        int n_bad_hold;
        int n_hold;
        int guard;

        // Reset state.
        do_reset();
        #1;
        check("rst_data", data_o, 32'd0);
        check("rst_valid", {31'd0, data_valid_o}, 32'd0);
        check("rst_err_miss", {31'd0, err_tlast_missing}, 32'd0);
        check("rst_err_unexp", {31'd0, err_tlast_unexpected}, 32'd0);
        check("rst_pkt", {16'd0, pkt_count}, 32'd0);
        check("rst_tready", {31'd0, s_axis_tready}, 32'd1);

        // Single word: visible exactly one cycle after the 4th byte.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check("sw_not_early", {31'd0, data_valid_o}, 32'd0);
        send_byte(8'h44, 1'b0);
        #1;
        check("sw_valid", {31'd0, data_valid_o}, 32'd1);
        check("sw_data", data_o, 32'h11223344);
        @(negedge core_clk);
        #1;
        check("sw_valid_drop", {31'd0, data_valid_o}, 32'd0);
        #2;
        check("sw_nwords", got.size(), 1);

        // Four back-to-back packets with correct framing.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 229; i++) begin
                exp_bytes.push_back(8'(i));
                send_byte(8'(i), i == 228);
            end
        end
        repeat (3) @(negedge core_clk);
        check_words("pk", 229);
        if (got.size() > 57) check("pk_word57", got[57], 32'hE4000102);
        check("pk_count", {16'd0, pkt_count}, 32'd4);
        check("pk_miss", n_miss, 0);
        check("pk_unexp", n_unexp, 0);

        // Backpressure: downstream stalls 10 cycles after the first word.
        do_reset();
        n_stall    = 0;
        n_bad_hold = 0;
        n_hold     = 0;
        for (int i = 0; i < 32; i++) exp_bytes.push_back(8'(i * 7 + 3));
        fork
            begin
                for (int i = 0; i < 32; i++) send_byte(8'(i * 7 + 3), 1'b0);
            end
            begin
                guard = 0;
                while (got.size() < 1 && guard < 100) begin
                    @(negedge core_clk);
                    guard++;
                end
                if (guard >= 100) check("bp_first_word_timeout", got.size(), 1);
                data_rdy_i = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    #3;
                    if (!s_axis_tready) n_stall++;
                    if (data_valid_o) begin
                        n_hold++;
                        if (data_o !== 32'h1F262D34) n_bad_hold++;
                    end
                    @(negedge core_clk);
                end
                data_rdy_i = 1'b1;
            end
        join
        repeat (3) @(negedge core_clk);
        check("bp_stall_seen", {31'd0, n_stall != 0}, 32'd1);
        check("bp_hold_seen", {31'd0, n_hold != 0}, 32'd1);
        check("bp_hold_stable", n_bad_hold, 0);
        check_words("bp", 8);

        // Early tlast on byte 100, then a clean 229-byte packet.
        do_reset();
        for (int i = 0; i < 100; i++) send_byte(8'(i), i == 99);
        for (int i = 0; i < 229; i++) send_byte(8'(i), i == 228);
        repeat (2) @(negedge core_clk);
        check("et_unexp", n_unexp, 1);
        check("et_miss", n_miss, 0);
        check("et_pkt", {16'd0, pkt_count}, 32'd2);

        // Missing tlast on byte 229, then a clean packet.
        do_reset();
        for (int i = 0; i < 229; i++) send_byte(8'(i), 1'b0);
        repeat (2) @(negedge core_clk);
        check("mt_miss", n_miss, 1);
        check("mt_pkt_hold", {16'd0, pkt_count}, 32'd0);
        for (int i = 0; i < 229; i++) send_byte(8'(i), i == 228);
        repeat (2) @(negedge core_clk);
        check("mt_miss_after", n_miss, 1);
        check("mt_unexp", n_unexp, 0);
        check("mt_pkt", {16'd0, pkt_count}, 32'd1);

        // Reset mid-word with a held output word.
        do_reset();
        data_rdy_i = 1'b0;
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
        #1;
        check("rw_held_valid", {31'd0, data_valid_o}, 32'd1);
        check("rw_held_data", data_o, 32'h01020304);
        @(negedge core_clk);
        rst_n = 1'b0;
        #1;
        check("rw_data", data_o, 32'd0);
        check("rw_valid", {31'd0, data_valid_o}, 32'd0);
        check("rw_errs", {30'd0, err_tlast_missing, err_tlast_unexpected}, 32'd0);
        check("rw_pkt", {16'd0, pkt_count}, 32'd0);
        @(negedge core_clk);
        rst_n      = 1'b1;
        data_rdy_i = 1'b1;
        got.delete();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        repeat (3) @(negedge core_clk);
        check("rw_nwords", got.size(), 1);
        if (got.size() > 0) check("rw_word", got[0], 32'hA1A2A3A4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
